seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic, WORD_SIZE-cycle restoring DIV (and shift-add MUL when SEQ_ALU_MUL_EN is defined).
// Latency 1 cycle (or WORD_SIZE+1 for DIV/MUL); result held while out_ready is low, new work accepted only in IDLE.
module seq_alu #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] B,
  input  logic [4:0]           ALU_Sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] ALU_Out,
  output logic [WORD_SIZE-1:0] ALU_Hi,
  output logic                 CarryOut,
  output logic                 Zero,
  output logic                 DivByZero
);

  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(W + 1);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_DIV = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rem_q, lo_q, b_q;
  logic           accept, last_iter, is_div, is_mul, start_iter;

  logic [W:0]     sum;
  logic [W-1:0]   res, res_hi;
  logic           res_c, res_dbz;

  logic [W:0]     div_shift, div_diff;
  logic [W-1:0]   div_rem_n, div_quo_n;
  logic [W-1:0]   iter_hi, iter_lo;
  logic           fin_c;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [4:0] OP_MUL = 5'd6;
  logic           mul_q;
  logic [W:0]     mul_sum;
  assign is_mul = (ALU_Sel == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_iter  = (cnt == CW'(W - 1));
  assign is_div     = (ALU_Sel == OP_DIV) && (B != '0);
  assign start_iter = is_div || is_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_iter ? ITER : DONE;
      ITER:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle results; the DIV arm is only ever used for the B == 0 case.
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    res     = A;
    res_hi  = '0;
    res_c   = 1'b0;
    res_dbz = 1'b0;
    case (ALU_Sel)
      OP_ADD:  begin res = sum[W-1:0]; res_c = sum[W]; end
      OP_SUB:  begin res = A - B; res_c = (A >= B); end
      OP_DIV:  begin res = '1; res_hi = A; res_dbz = 1'b1; end
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      default: res = A;
    endcase
  end

  // One restoring-division step: rem_q holds the partial remainder, lo_q the dividend shifting into quotient.
  always_comb begin
    div_shift = {rem_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!div_diff[W]) begin
      div_rem_n = div_diff[W-1:0];
      div_quo_n = {lo_q[W-2:0], 1'b1};
    end else begin
      div_rem_n = div_shift[W-1:0];
      div_quo_n = {lo_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    iter_hi = div_rem_n;
    iter_lo = div_quo_n;
    fin_c   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul_sum = {1'b0, rem_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    if (mul_q) begin
      iter_hi = mul_sum[W:1];
      iter_lo = {mul_sum[0], lo_q[W-1:1]};
      fin_c   = (iter_hi != '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem_q     <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      ALU_Out   <= '0;
      ALU_Hi    <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      DivByZero <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mul_q     <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      rem_q <= '0;
      lo_q  <= is_mul ? B : A;
      b_q   <= is_mul ? A : B;
`ifdef SEQ_ALU_MUL_EN
      mul_q <= is_mul;
`endif
      if (!start_iter) begin
        ALU_Out   <= res;
        ALU_Hi    <= res_hi;
        CarryOut  <= res_c;
        Zero      <= (res == '0);
        DivByZero <= res_dbz;
      end
    end else if (state == ITER) begin
      cnt   <= cnt + CW'(1);
      rem_q <= iter_hi;
      lo_q  <= iter_lo;
      if (last_iter) begin
        ALU_Out   <= iter_lo;
        ALU_Hi    <= iter_hi;
        CarryOut  <= fin_c;
        Zero      <= (iter_lo == '0);
        DivByZero <= 1'b0;
      end
    end
  end

endmodule
